// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch resolver.
// It compares two operands under a 4-bit branch code and registers the
// actual outcome. It raises a one-cycle mispredict/redirect pulse when the
// outcome differs from the fetch-time prediction. It also owns the 2-bit
// saturating-counter BHT that the IF stage reads combinationally.
// Optional feature macro: BRANCH_RESOLVE_STATS_EN adds resolve/mispredict
// counters (stat_branches, stat_mispredicts).
// Handshake: there is no backpressure. resolve_valid is a one-cycle
// qualifier for resolve_taken, and mispredict qualifies redirect_pc.
module branch_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic [3:0]        ex_branch,
    input  logic [DATA_W-1:0] ex_op1,
    input  logic [DATA_W-1:0] ex_op2,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [PC_W-1:0]   ex_target,
    input  logic              ex_pred_taken,
    output logic              resolve_valid,
    output logic              resolve_taken,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]        bht_q [BHT_DEPTH];
    logic [1:0]        bht_d [BHT_DEPTH];
    logic              resolve_valid_q, resolve_valid_d;
    logic              resolve_taken_q, resolve_taken_d;
    logic              mispredict_q, mispredict_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;

    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic              is_branch;
    logic              op_eq;
    logic              op_lt;
    logic              outcome;
    logic              resolve_event;
    logic              unused_if_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_if_pc_bits = ^{if_pc[1:0], if_pc[PC_W-1:IDX_W+2]};

    // The prediction reads the stored counter with no bypass of a same-cycle update.
    assign if_pred_taken = bht_q[if_idx][1];

    assign is_branch = (ex_branch[2:0] != 3'b000) && (ex_branch[2:0] != 3'b111);
    assign op_eq     = (ex_op1 == ex_op2);
    assign op_lt     = ex_branch[3] ? (ex_op1 < ex_op2)
                                    : ($signed(ex_op1) < $signed(ex_op2));

    // The wrong-path instruction in EX during a mispredict pulse is squashed.
    assign resolve_event = ex_valid && is_branch && !mispredict_q;

    // Decode the condition code into the taken/not-taken outcome.
    always_comb begin
        outcome = 1'b0;
        case (ex_branch[2:0])
            3'b001:  outcome = op_eq;
            3'b010:  outcome = !op_eq;
            3'b011:  outcome = op_lt;
            3'b100:  outcome = !op_lt && !op_eq;
            3'b101:  outcome = op_lt || op_eq;
            3'b110:  outcome = !op_lt;
            default: outcome = 1'b0;
        endcase
    end

    // Next-state for the resolve outputs and the BHT counter being trained.
    always_comb begin
        resolve_valid_d = 1'b0;
        resolve_taken_d = 1'b0;
        mispredict_d    = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        bht_d           = bht_q;
        if (resolve_event) begin
            resolve_valid_d = 1'b1;
            resolve_taken_d = outcome;
            mispredict_d    = (outcome != ex_pred_taken);
            redirect_pc_d   = outcome ? ex_target
                                      : ex_pc + {{(PC_W-3){1'b0}}, 3'b100};
            if (outcome) begin
                if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            end else begin
                if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
            end
        end
    end

    // State registers. Reset wins over any concurrent resolve event.
    always_ff @(posedge clk) begin
        if (rst) begin
            resolve_valid_q <= 1'b0;
            resolve_taken_q <= 1'b0;
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else begin
            resolve_valid_q <= resolve_valid_d;
            resolve_taken_q <= resolve_taken_d;
            mispredict_q    <= mispredict_d;
            redirect_pc_q   <= redirect_pc_d;
            bht_q           <= bht_d;
        end
    end

    assign resolve_valid = resolve_valid_q;
    assign resolve_taken = resolve_taken_q;
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Count resolve events and the mispredicting ones, wrapping naturally.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (resolve_event) begin
            stat_branches_d = stat_branches_q + 32'd1;
            if (outcome != ex_pred_taken) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    // Statistic counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif
endmodule
